// File: rtl/hex_entry_ctrl.sv
// hex_entry_ctrl: debounced push-button editor for a 4-digit hex value with cursor
// Define HEX_ENTRY_AUTOREPEAT_EN to add auto-repeat on held inc/dec buttons.
module hex_entry_ctrl #(
  parameter int DEBOUNCE_CYC = 500000,
  parameter int REPEAT_DLY = 50000000,
  parameter int REPEAT_PER = 10000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_inc,
  input  logic        btn_dec,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        ld,
  input  logic [15:0] ld_val,
  output logic [15:0] num,
  output logic [1:0]  cursor,
  output logic [3:0]  cursor_an,
  output logic        upd
);
  localparam int CW = $clog2(DEBOUNCE_CYC);
  logic [3:0] raw, s1, s2, db, db_d, rise, press, evt;
  logic [CW-1:0] cnt [4];
  logic [15:0] num_n;
  logic [1:0] cur_n;
  logic inc, dec, lft, rgt;
  assign raw = {btn_right, btn_left, btn_dec, btn_inc};
  assign rise = db & ~db_d;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      db <= '0;
      db_d <= '0;
      press <= '0;
      for (int k = 0; k < 4; k++) cnt[k] <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      db_d <= db;
      press <= rise;
      for (int k = 0; k < 4; k++)
        if (s2[k] == db[k]) cnt[k] <= '0;
        else if (cnt[k] == CW'(DEBOUNCE_CYC - 1)) begin
          db[k] <= s2[k];
          cnt[k] <= '0;
        end else cnt[k] <= cnt[k] + 1'b1;
    end
`ifdef HEX_ENTRY_AUTOREPEAT_EN
  logic [1:0] rep, first;
  logic [31:0] rcnt [2];
  // Timer restarts on the debounced rise, so it lines up with the press pulse one cycle later
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rep <= '0;
      first <= '0;
      rcnt[0] <= '0;
      rcnt[1] <= '0;
    end else
      for (int k = 0; k < 2; k++)
        if (!db[k]) rep[k] <= 1'b0;
        else if (rise[k]) begin
          rcnt[k] <= '0;
          first[k] <= 1'b1;
          rep[k] <= 1'b0;
        end else if (rcnt[k] == (first[k] ? 32'(REPEAT_DLY - 1) : 32'(REPEAT_PER - 1))) begin
          rep[k] <= 1'b1;
          rcnt[k] <= '0;
          first[k] <= 1'b0;
        end else begin
          rep[k] <= 1'b0;
          rcnt[k] <= rcnt[k] + 1'b1;
        end
  assign evt = press | {2'b00, rep};
`else
  assign evt = press;
`endif
  assign {rgt, lft, dec, inc} = evt;
  always_comb begin
    num_n = ld ? ld_val : num;
    if (!ld && (inc ^ dec)) num_n[4*cursor +: 4] = num[4*cursor +: 4] + (inc ? 4'd1 : 4'hF);
    cur_n = (!ld && (lft ^ rgt)) ? cursor + (lft ? 2'd1 : 2'd3) : cursor;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      num <= '0;
      cursor <= '0;
      cursor_an <= 4'b1110;
      upd <= 1'b0;
    end else begin
      num <= num_n;
      cursor <= cur_n;
      cursor_an <= ~(4'b0001 << cur_n);
      upd <= ld | (num_n != num) | (cur_n != cursor);
    end
endmodule
